// File: rtl/heap_port_arbiter.sv
// Round-robin arbiter sharing one priority-queue heap among NUM_PORTS requesters.
// One heap transaction in flight; pop results are steered back to the issuing port.
module heap_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int W_PORT    = 2,
    parameter int W_D       = 32,
    parameter int W_CNT     = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_PORTS-1:0]     push_valid,
    input  logic [NUM_PORTS*W_D-1:0] push_data,
    output logic [NUM_PORTS-1:0]     push_ready,
    input  logic [NUM_PORTS-1:0]     pop_req,
    output logic [NUM_PORTS-1:0]     pop_ack,
    output logic [NUM_PORTS-1:0]     pop_valid,
    output logic [W_D-1:0]           pop_data,
    output logic                     pop_empty_err,
    output logic                     heap_write_valid,
    output logic [W_D-1:0]           heap_write_data,
    input  logic                     heap_write_ready,
    output logic                     heap_read_request,
    input  logic [W_D-1:0]           heap_read_data,
    input  logic                     heap_read_valid,
    input  logic                     heap_read_empty,
    output logic                     busy,
    output logic [W_CNT-1:0]         entry_count
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, POP_ERR} state_t;

    state_t               state_q;
    logic [W_PORT-1:0]    rr_ptr_q;
    logic [W_PORT-1:0]    id_q;
    logic [W_D-1:0]       wdata_q;
    logic                 wvalid_q;
    logic                 rreq_q;
    logic [NUM_PORTS-1:0] pop_valid_q;
    logic [W_D-1:0]       pop_data_q;
    logic                 err_q;
    logic [W_CNT-1:0]     cnt_q;

    logic                 found;
    logic [W_PORT-1:0]    gnt;
    logic                 gnt_pop;
    logic [W_D-1:0]       gnt_data;
    logic [NUM_PORTS-1:0] gnt_oh;
    logic [NUM_PORTS-1:0] id_oh;
    logic [W_PORT-1:0]    rr_ptr_d;
    logic                 arb_en;

    // Scan ports starting at rr_ptr; rr_ptr is always < NUM_PORTS.
    always_comb begin
        int idx;
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && (push_valid[idx] || pop_req[idx])) begin
                found = 1'b1;
                gnt   = W_PORT'(idx);
            end
        end
    end

    always_comb begin
        gnt_pop  = 1'b0;
        gnt_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt == W_PORT'(i)) begin
                gnt_pop  = pop_req[i];
                gnt_data = push_data[i*W_D +: W_D];
            end
        end
    end

    assign gnt_oh   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << gnt;
    assign id_oh    = {{(NUM_PORTS-1){1'b0}}, 1'b1} << id_q;
    assign rr_ptr_d = (gnt == W_PORT'(NUM_PORTS-1)) ? '0 : gnt + W_PORT'(1);
    assign arb_en   = (state_q == IDLE) && found;

    assign pop_ack    = (arb_en && gnt_pop)  ? gnt_oh : '0;
    assign push_ready = (arb_en && !gnt_pop) ? gnt_oh : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            wdata_q     <= '0;
            wvalid_q    <= 1'b0;
            rreq_q      <= 1'b0;
            pop_valid_q <= '0;
            pop_data_q  <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pop_valid_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        rr_ptr_q <= rr_ptr_d;
                        id_q     <= gnt;
                        if (gnt_pop) begin
                            // Empty pops answer at the grant edge; POP_ERR is a cooldown.
                            if (heap_read_empty) begin
                                pop_valid_q <= gnt_oh;
                                err_q       <= 1'b1;
                                pop_data_q  <= '0;
                                state_q     <= POP_ERR;
                            end else begin
                                rreq_q  <= 1'b1;
                                state_q <= POP;
                            end
                        end else begin
                            wdata_q  <= gnt_data;
                            wvalid_q <= 1'b1;
                            state_q  <= PUSH;
                        end
                    end
                end
                PUSH: begin
                    if (heap_write_ready) begin
                        wvalid_q <= 1'b0;
                        cnt_q    <= cnt_q + W_CNT'(1);
                        state_q  <= IDLE;
                    end
                end
                POP: begin
                    if (heap_read_valid) begin
                        rreq_q      <= 1'b0;
                        pop_data_q  <= heap_read_data;
                        pop_valid_q <= id_oh;
                        err_q       <= 1'b0;
                        cnt_q       <= cnt_q - W_CNT'(1);
                        state_q     <= IDLE;
                    end
                end
                POP_ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign heap_write_valid  = wvalid_q;
    assign heap_write_data   = wdata_q;
    assign heap_read_request = rreq_q;
    assign pop_valid         = pop_valid_q;
    assign pop_data          = pop_data_q;
    assign pop_empty_err     = err_q;
    assign entry_count       = cnt_q;
    assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_heap_port_arbiter.sv
// Directed bench for heap_port_arbiter with a small min-heap behavioural model.
// Table-driven push/pop transactions plus hand sequences for multi-cycle corners.
module tb_heap_port_arbiter;

    localparam int NP = 4;
    localparam int WD = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NP-1:0]   push_valid = '0;
    logic [NP*WD-1:0] push_data = '0;
    logic [NP-1:0]   push_ready;
    logic [NP-1:0]   pop_req = '0;
    logic [NP-1:0]   pop_ack;
    logic [NP-1:0]   pop_valid;
    logic [WD-1:0]   pop_data;
    logic            pop_empty_err;
    logic            hwv;
    logic [WD-1:0]   hwd;
    logic            wready = 1'b1;
    logic            hrr;
    logic [WD-1:0]   rdata = '0;
    logic            rv = 1'b0;
    logic            rempty = 1'b1;
    logic            busy;
    logic [31:0]     entry_count;

    bit rd_stall = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    int overlap = 0;

    heap_port_arbiter dut (
        .CLK               (clk),
        .RST               (rst),
        .push_valid        (push_valid),
        .push_data         (push_data),
        .push_ready        (push_ready),
        .pop_req           (pop_req),
        .pop_ack           (pop_ack),
        .pop_valid         (pop_valid),
        .pop_data          (pop_data),
        .pop_empty_err     (pop_empty_err),
        .heap_write_valid  (hwv),
        .heap_write_data   (hwd),
        .heap_write_ready  (wready),
        .heap_read_request (hrr),
        .heap_read_data    (rdata),
        .heap_read_valid   (rv),
        .heap_read_empty   (rempty),
        .busy              (busy),
        .entry_count       (entry_count)
    );

    always #5 clk = ~clk;

    // Min-heap model: write accepted when valid&ready; read answered one cycle after request.
    logic [WD-1:0] hq[$];
    always @(posedge clk) begin
        if (rst) begin
            hq.delete();
            rv     <= 1'b0;
            rempty <= 1'b1;
        end else begin
            if (hwv && wready) hq.push_back(hwd);
            if (rv) begin
                rv <= 1'b0;
            end else if (hrr && !rd_stall && hq.size() > 0) begin
                int mi;
                mi = 0;
                foreach (hq[i]) if (hq[i] < hq[mi]) mi = i;
                rdata <= hq[mi];
                hq.delete(mi);
                rv <= 1'b1;
            end
            rempty <= (hq.size() == 0);
        end
    end

    always @(negedge clk) if (hwv && hrr) overlap++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 50; t++) begin
            if (!busy) break;
            @(negedge clk); #1;
        end
        check("wait_idle", busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push_valid = '0;
        pop_req = '0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic do_txn(input int port, input bit pop, input logic [31:0] d,
                          input bit exp_err, input logic [31:0] exp_d, input int exp_cnt);
        bit got;
        logic [NP-1:0] oh;
        oh = NP'(1) << port;
        @(negedge clk);
        if (pop) pop_req[port] = 1'b1;
        else begin
            push_valid[port] = 1'b1;
            push_data[port*WD +: WD] = d;
        end
        #1;
        got = 0;
        for (int t = 0; t < 50; t++) begin
            if ((pop ? pop_ack : push_ready) != 0) begin
                got = 1;
                break;
            end
            @(negedge clk); #1;
        end
        check("grant_seen", got, 1);
        if (got) begin
            check("grant_bit", pop ? pop_ack : push_ready, oh);
            check("other_ack_zero", pop ? push_ready : pop_ack, 0);
        end
        @(negedge clk);
        pop_req = '0;
        push_valid = '0;
        #1;
        if (got && pop && exp_err) begin
            check("err_pop_valid", pop_valid, oh);
            check("err_flag", pop_empty_err, 1);
            check("err_data", pop_data, 0);
            check("err_no_rreq", hrr, 0);
        end else if (got && pop) begin
            check("pop_rreq", hrr, 1);
            @(negedge clk);
            @(negedge clk); #1;
            check("pop_valid", pop_valid, oh);
            check("pop_data", pop_data, exp_d);
            check("pop_err", pop_empty_err, 0);
        end else if (got) begin
            check("push_wvalid", hwv, 1);
            check("push_wdata", hwd, d);
        end
        wait_idle();
        check("entry_count", entry_count, exp_cnt);
    endtask

    typedef struct {
        int          port;
        bit          pop;
        logic [31:0] data;
        bit          exp_err;
        logic [31:0] exp_data;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int grants[5];
        int ng;
        int ok;
        bit saw_pop;
        bit saw_push;
        logic [31:0] got_d;

        vecs[0] = '{0, 0, 32'd7, 0, 32'd0, 1};
        vecs[1] = '{0, 0, 32'd3, 0, 32'd0, 2};
        vecs[2] = '{0, 0, 32'd9, 0, 32'd0, 3};
        vecs[3] = '{1, 1, 32'd0, 0, 32'd3, 2};
        vecs[4] = '{1, 1, 32'd0, 0, 32'd7, 1};
        vecs[5] = '{1, 1, 32'd0, 0, 32'd9, 0};
        vecs[6] = '{2, 1, 32'd0, 1, 32'd0, 0};
        vecs[7] = '{1, 0, 32'd5, 0, 32'd0, 1};
        vecs[8] = '{3, 1, 32'd0, 0, 32'd5, 0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_wvalid", hwv, 0);
        check("rst_wdata", hwd, 0);
        check("rst_rreq", hrr, 0);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_pop_data", pop_data, 0);
        check("rst_err", pop_empty_err, 0);
        check("rst_count", entry_count, 0);

        foreach (vecs[i])
            do_txn(vecs[i].port, vecs[i].pop, vecs[i].data,
                   vecs[i].exp_err, vecs[i].exp_data, vecs[i].exp_cnt);

        // Round robin from rr_ptr=0 with all ports pushing.
        do_reset();
        for (int i = 0; i < NP; i++) push_data[i*WD +: WD] = 32'h100 + i;
        push_valid = '1;
        #1;
        ng = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            if (push_ready != 0) begin
                for (int i = 0; i < NP; i++) if (push_ready[i]) grants[ng] = i;
                ng++;
            end
            if (ng < 5) begin
                @(negedge clk); #1;
            end
        end
        @(negedge clk);
        push_valid = '0;
        check("rr_ngrants", ng, 5);
        for (int i = 0; i < 5; i++) check("rr_order", grants[i], i % NP);
        #1;
        wait_idle();
        check("rr_count", entry_count, 5);

        // Port 3 push and pop together: pop first, push later.
        @(negedge clk);
        push_valid[3] = 1'b1;
        push_data[3*WD +: WD] = 32'h55;
        pop_req[3] = 1'b1;
        #1;
        check("p3_pop_first", pop_ack, 4'b1000);
        check("p3_no_push", push_ready, 0);
        @(negedge clk);
        pop_req = '0;
        #1;
        saw_pop = 0;
        saw_push = 0;
        got_d = '0;
        for (int c = 0; c < 40 && !saw_push; c++) begin
            if (pop_valid == 4'b1000) begin
                saw_pop = 1;
                got_d = pop_data;
            end
            if (push_ready == 4'b1000) saw_push = 1;
            if (!saw_push) begin
                @(negedge clk); #1;
            end
        end
        @(negedge clk);
        push_valid = '0;
        check("p3_pop_seen", saw_pop, 1);
        check("p3_pop_data", got_d, 32'h100);
        check("p3_push_seen", saw_push, 1);
        #1;
        wait_idle();
        check("p3_count", entry_count, 5);

        // Write-ready stall with other requests pending.
        wready = 1'b0;
        @(negedge clk);
        push_valid[0] = 1'b1;
        push_data[0 +: WD] = 32'hDEADBEEF;
        #1;
        check("stall_grant", push_ready, 4'b0001);
        @(negedge clk);
        push_valid = 4'b0100;
        pop_req = 4'b0010;
        ok = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (hwv === 1'b1 && hwd === 32'hDEADBEEF && busy === 1'b1 &&
                push_ready === 4'b0 && pop_ack === 4'b0) ok++;
            @(negedge clk);
        end
        check("stall_stable_cycles", ok, 20);
        push_valid = '0;
        pop_req = '0;
        wready = 1'b1;
        #1;
        wait_idle();
        check("stall_count", entry_count, 6);

        // Reset while a pop request is outstanding.
        rd_stall = 1'b1;
        @(negedge clk);
        pop_req[1] = 1'b1;
        #1;
        check("rpop_grant", pop_ack, 4'b0010);
        @(negedge clk);
        pop_req = '0;
        #1;
        check("rpop_rreq", hrr, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_stall = 1'b0;
        #1;
        check("rpop_busy", busy, 0);
        check("rpop_rreq_clr", hrr, 0);
        check("rpop_wvalid", hwv, 0);
        check("rpop_wdata", hwd, 0);
        check("rpop_pop_valid", pop_valid, 0);
        check("rpop_pop_data", pop_data, 0);
        check("rpop_err", pop_empty_err, 0);
        check("rpop_count", entry_count, 0);
        check("rpop_acks", {push_ready, pop_ack}, 0);
        repeat (4) @(negedge clk);
        #1;
        check("rpop_no_response", pop_valid, 0);

        check("no_wr_rd_overlap", overlap, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
